alu_mul_unit: RTL and testbench

//  Multi-cycle integer multiplier in the EX stage, beside the single-cycle ALU.

---
 rtl/cpu_pkg.sv | 25 ++
 rtl/alu_mul_unit.sv | 104 ++++++++++
 tb/tb_alu_mul_unit.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU control codes, default datapath width, multiplier FSM states.
package cpu_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SLL  = 4'b0011;
  localparam logic [3:0] ALU_MUL  = 4'b0100;
  localparam logic [3:0] ALU_MULH = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_XOR  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1010;
  localparam logic [3:0] ALU_SRA  = 4'b1011;
  localparam logic [3:0] ALU_INV  = 4'b1111;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'b00,
    MUL_CALC = 2'b01,
    MUL_SIGN = 2'b10,
    MUL_DONE = 2'b11
  } mul_state_e;

endpackage

// File: rtl/alu_mul_unit.sv
// Multi-cycle shift-add multiplier (MUL/MULH) for the EX stage with start/busy/done handshake.
module alu_mul_unit
  import cpu_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CNT_W = $clog2(XLEN);
  localparam int unsigned ACC_W = 2 * XLEN;

  mul_state_e         state;
  logic [CNT_W-1:0]   cnt;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   mcand;
  logic [XLEN-1:0]    mplier;
  logic               sign_q;
  logic               hi_q;

  logic               accept_c;
  logic [XLEN-1:0]    abs_a_c;
  logic [XLEN-1:0]    abs_b_c;
  logic [ACC_W-1:0]   product_c;

  // Request qualification and operand magnitudes; |-2^(XLEN-1)| wraps to itself, which is the correct unsigned value.
  always_comb begin
    accept_c  = start && ((alu_ctrl == ALU_MUL) || (alu_ctrl == ALU_MULH)) &&
                ((state == MUL_IDLE) || (state == MUL_DONE));
    abs_a_c   = op_a[XLEN-1] ? (~op_a + XLEN'(1)) : op_a;
    abs_b_c   = op_b[XLEN-1] ? (~op_b + XLEN'(1)) : op_b;
    product_c = sign_q ? (~acc + ACC_W'(1)) : acc;
  end

  // FSM, counter and shift-add datapath; flush has priority over any request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= MUL_IDLE;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      sign_q <= 1'b0;
      hi_q   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        state <= MUL_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          MUL_IDLE, MUL_DONE: begin
            if (accept_c) begin
              mcand  <= {{XLEN{1'b0}}, abs_a_c};
              mplier <= abs_b_c;
              sign_q <= op_a[XLEN-1] ^ op_b[XLEN-1];
              hi_q   <= (alu_ctrl == ALU_MULH);
              cnt    <= CNT_W'(XLEN - 1);
              acc    <= '0;
              busy   <= 1'b1;
              state  <= MUL_CALC;
            end else begin
              state  <= MUL_IDLE;
            end
          end
          MUL_CALC: begin
            if (mplier[0]) begin
              acc <= acc + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - CNT_W'(1);
            if (cnt == '0) begin
              state <= MUL_SIGN;
            end
          end
          MUL_SIGN: begin
            result <= hi_q ? product_c[ACC_W-1:XLEN] : product_c[XLEN-1:0];
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= MUL_DONE;
          end
          default: begin
            state <= MUL_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_mul_unit.sv
// Self-checking bench for alu_mul_unit: directed corner cases plus random MUL/MULH against a signed reference.
module tb_alu_mul_unit;

  localparam int unsigned XLEN = 32;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic [3:0]      alu_ctrl;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  int total;
  int bad;

  alu_mul_unit #(.XLEN(XLEN)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .alu_ctrl (alu_ctrl),
    .op_a     (op_a),
    .op_b     (op_b),
    .flush    (flush),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: full signed 64-bit product, then pick the requested word.
  function automatic logic [31:0] ref_mul(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b);
    longint pa;
    longint pb;
    logic [63:0] p;
    pa = longint'($signed(a));
    pb = longint'($signed(b));
    p  = 64'(pa * pb);
    return (ctrl == 4'b0101) ? p[63:32] : p[31:0];
  endfunction

  // Call right after a negedge: present a request for the next rising edge.
  task automatic launch(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b);
    start    = 1'b1;
    alu_ctrl = ctrl;
    op_a     = a;
    op_b     = b;
  endtask

  // Drop start after the accepting edge, then count busy cycles and edges until done (bounded).
  task automatic wait_result(output logic [31:0] res, output int busy_n, output int edges, output logic got_done);
    int n;
    @(negedge clk);
    start    = 1'b0;
    op_a     = $urandom;
    op_b     = $urandom;
    n        = 1;
    busy_n   = 0;
    got_done = 1'b0;
    forever begin
      if (busy) busy_n++;
      if (done) begin
        got_done = 1'b1;
        break;
      end
      if (n >= 100) break;
      @(negedge clk);
      n++;
    end
    edges = n - 1;
    res   = result;
  endtask

  task automatic run_op(input string tag, input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp);
    logic [31:0] res;
    int bn, ed;
    logic gd;
    @(negedge clk);
    launch(ctrl, a, b);
    wait_result(res, bn, ed, gd);
    check({tag, "_done"}, 64'(gd), 64'd1);
    check(tag, 64'(res), 64'(exp));
  endtask

  initial begin
    logic [31:0] res;
    logic [31:0] prev;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctrl;
    int bn, ed, dcnt, bcnt;
    logic gd;

    total    = 0;
    bad      = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    flush    = 1'b0;
    alu_ctrl = 4'b0000;
    op_a     = '0;
    op_b     = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    rst_n = 1'b1;

    // 7 x -3 with latency and busy width
    @(negedge clk);
    launch(4'b0100, 32'd7, 32'hFFFFFFFD);
    wait_result(res, bn, ed, gd);
    check("mul7m3_done", 64'(gd), 64'd1);
    check("mul7m3", 64'(res), 64'hFFFFFFEB);
    check("mul7m3_busy_cycles", 64'(bn), 64'(XLEN + 1));
    check("mul7m3_latency", 64'(ed), 64'(XLEN + 1));
    @(negedge clk);
    check("done_one_cycle", 64'(done), 64'd0);

    run_op("mulh_min_min", 4'b0101, 32'h80000000, 32'h80000000, 32'h40000000);
    run_op("mul_min_min", 4'b0100, 32'h80000000, 32'h80000000, 32'h00000000);
    run_op("mulh_m1_2", 4'b0101, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF);
    run_op("mul_m1_2", 4'b0100, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE);
    run_op("mulh_zero", 4'b0101, 32'h00000000, 32'h80000001, 32'h00000000);
    prev = 32'h00000000;

    // flush in the 10th CALC cycle
    @(negedge clk);
    launch(4'b0100, 32'h12345, 32'h777);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    dcnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    check("flush_no_done", 64'(dcnt), 64'd0);
    check("flush_result_kept", 64'(result), 64'(prev));
    run_op("mul3x4", 4'b0100, 32'd3, 32'd4, 32'd12);

    // non-multiply code held on start
    @(negedge clk);
    launch(4'b0010, 32'd5, 32'd6);
    dcnt = 0;
    bcnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dcnt++;
      if (busy) bcnt++;
    end
    start = 1'b0;
    check("add_no_busy", 64'(bcnt), 64'd0);
    check("add_no_done", 64'(dcnt), 64'd0);

    // back-to-back: new request presented during the DONE cycle
    @(negedge clk);
    launch(4'b0100, 32'd100, 32'hFFFFFF9C);
    wait_result(res, bn, ed, gd);
    check("b2b_first", 64'(res), 64'(ref_mul(4'b0100, 32'd100, 32'hFFFFFF9C)));
    launch(4'b0101, 32'h7FFFFFFF, 32'h7FFFFFFF);
    wait_result(res, bn, ed, gd);
    check("b2b_second_done", 64'(gd), 64'd1);
    check("b2b_second_latency", 64'(ed), 64'(XLEN + 1));
    check("b2b_second", 64'(res), 64'h3FFFFFFF);

    // async reset mid-CALC
    @(negedge clk);
    launch(4'b0100, 32'd9, 32'd9);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    check("arst_result", 64'(result), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    check("arst_no_done", 64'(dcnt), 64'd0);

    // random MUL/MULH
    for (int i = 0; i < 1000; i++) begin
      ctrl = ($urandom_range(0, 1) == 0) ? 4'b0100 : 4'b0101;
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 9))
        0: a = 32'h80000000;
        1: b = 32'h00000000;
        2: a = 32'hFFFFFFFF;
        3: b = 32'h7FFFFFFF;
        default: ;
      endcase
      @(negedge clk);
      launch(ctrl, a, b);
      wait_result(res, bn, ed, gd);
      check("rand_done", 64'(gd), 64'd1);
      check($sformatf("rand_%0d_%h_%h_%h", i, ctrl, a, b), 64'(res), 64'(ref_mul(ctrl, a, b)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
